mult_control: RTL and testbench
===============================

MULT_CONTROL -- requirements
Module: mult_control

Interface
REQ-001 Parameter NUM_BITS, default 8, multiplier operand width and number of add/shift steps.
REQ-002 Clk  input  1  system clock; all state changes on the rising edge.
REQ-003 Reset_n  input  1  reset, asynchronous and active-low.
REQ-004 Run  input  1  raw push button (active-high) requesting one multiplication.
REQ-005 Load_Clear  input  1  raw push button (active-high) requesting load of B and clear of A/X.
REQ-006 M  input  1  current multiplier LSB (B[0]) from the datapath.
REQ-007 Clr_Ld  output  1  load B from switches and clear A and X.
REQ-008 Clr_A  output  1  clear A and X only.
REQ-009 Add  output  1  add S into A:X.
REQ-010 Sub  output  1  subtract S from A:X (two's complement).
REQ-011 Shift  output  1  arithmetic right shift of X:A:B by one.
REQ-012 Busy  output  1  multiplication in progress.
REQ-013 Done  output  1  product valid; waiting for Run release.

Function
REQ-014 Run and Load_Clear SHALL each pass through a two-flop synchronizer (2-cycle latency) before use.
REQ-015 States SHALL be IDLE, CLRA, ADD, SHIFT, HOLD.
REQ-016 Start SHALL mean synchronized Run = 1 and its previous registered value = 0 (rising edge).
REQ-017 IDLE: Load_Clear_sync = 1 -> Clr_Ld = 1 that cycle, stay IDLE; else start -> CLRA; else stay.
REQ-018 Load_Clear_sync and start in the same IDLE cycle: Load_Clear wins, start discarded (re-press needed).
REQ-019 CLRA: Clr_A = 1 for exactly one cycle, step counter cleared to 0, -> ADD.
REQ-020 ADD: if M = 1, Add = 1 when counter < NUM_BITS-1, Sub = 1 when counter = NUM_BITS-1; if M = 0 neither; -> SHIFT.
REQ-021 SHIFT: Shift = 1; counter = NUM_BITS-1 -> HOLD, else counter +1 and -> ADD.
REQ-022 Counter width SHALL be clog2(NUM_BITS); no wrap occurs since exit happens at NUM_BITS-1.
REQ-023 Busy = 1 in CLRA, ADD, SHIFT; busy span SHALL be exactly 1 + 2*NUM_BITS cycles (17 for 8).
REQ-024 HOLD: Done = 1; synchronized Run = 0 -> IDLE; otherwise stay (one multiplication per press).
REQ-025 Run and Load_Clear SHALL be ignored in CLRA, ADD, SHIFT; Load_Clear in HOLD ignored.
REQ-026 At most one of Clr_Ld, Clr_A, Add, Sub, Shift SHALL be high in any cycle.
REQ-027 Add/Sub SHALL be combinational from state, counter and M; all other outputs decoded from state only.

Reset
REQ-028 Reset_n low SHALL immediately force IDLE, counter 0, synchronizer and edge flops 0, all outputs 0.
REQ-029 Reset mid-multiplication SHALL abort with no further control pulse; datapath contents unspecified.
REQ-030 Run held high through reset release SHALL produce one start (edge flop resets to 0).

Structure
REQ-031 Package mult_ctrl_pkg SHALL hold the state enum type, NUM_BITS default and CNT_W constant.
REQ-032 Sub-module sync_2ff (one-bit two-flop synchronizer, async active-low reset) SHALL be instantiated per button.

Verification
REQ-033 Reset: Reset_n low with Run = 1 -> all outputs 0, state IDLE, no pulse until release.
REQ-034 Load: Load_Clear high 3 cycles in IDLE -> Clr_Ld high 3 cycles starting 2 cycles after press, Busy = 0.
REQ-035 Multiply, M held 1 (B = 0xFF, S = 0xFE): Run press -> Clr_A 1 cycle, 7 Add and 1 Sub (last), 8 Shift interleaved, Busy 17 cycles, then Done until Run released.
REQ-036 Multiply, M held 0: Run press -> zero Add/Sub, 8 Shift pulses, Busy 17 cycles.
REQ-037 Run held 50 cycles -> exactly one multiplication; second press after release -> second multiplication.
REQ-038 Reset_n pulsed low at cycle 6 of Busy -> IDLE next edge, no further Add/Sub/Shift; Load_Clear and Run pressed together in IDLE -> Clr_Ld only, no start.

Source files
------------

// File: rtl/mult_ctrl_pkg.sv
// Shared types and constants for the add/shift multiplier controller.
// Holds the state encoding, the default operand width and the matching step-counter width.
package mult_ctrl_pkg;

   localparam int NUM_BITS_DEF = 8;
   localparam int CNT_W        = $clog2(NUM_BITS_DEF);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      CLRA  = 3'd1,
      ADD   = 3'd2,
      SHIFT = 3'd3,
      HOLD  = 3'd4
   } state_t;

endpackage

// File: rtl/sync_2ff.sv
// One-bit two-flop synchronizer for an asynchronous push-button input.
module sync_2ff (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);

   logic meta;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta <= 1'b0;
         q    <= 1'b0;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/mult_control.sv
// Sequencer for a shift-add signed multiplier: one clear, then NUM_BITS add/shift steps,
// with the final step subtracting to account for the sign bit of the multiplier.
import mult_ctrl_pkg::*;

module mult_control #(
   parameter int NUM_BITS = NUM_BITS_DEF
) (
   input  logic Clk,
   input  logic Reset_n,
   input  logic Run,
   input  logic Load_Clear,
   input  logic M,
   output logic Clr_Ld,
   output logic Clr_A,
   output logic Add,
   output logic Sub,
   output logic Shift,
   output logic Busy,
   output logic Done
);

   localparam int CW = (NUM_BITS > 1) ? $clog2(NUM_BITS) : 1;
   localparam logic [CW-1:0] LAST = CW'(NUM_BITS - 1);

   state_t        state;
   logic [CW-1:0] cnt;
   logic          run_sync;
   logic          ld_sync;
   logic          run_prev;
   logic          start;
   logic          last_step;

   sync_2ff u_sync_run (
      .clk   (Clk),
      .rst_n (Reset_n),
      .d     (Run),
      .q     (run_sync)
   );

   sync_2ff u_sync_ld (
      .clk   (Clk),
      .rst_n (Reset_n),
      .d     (Load_Clear),
      .q     (ld_sync)
   );

   // A held button produces a single start; run_prev tracks Run in every state.
   assign start     = run_sync & ~run_prev;
   assign last_step = (cnt == LAST);

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         state    <= IDLE;
         cnt      <= '0;
         run_prev <= 1'b0;
      end else begin
         run_prev <= run_sync;
         case (state)
            IDLE: begin
               if (!ld_sync && start)
                  state <= CLRA;
            end
            CLRA: begin
               cnt   <= '0;
               state <= ADD;
            end
            ADD: begin
               state <= SHIFT;
            end
            SHIFT: begin
               if (last_step) begin
                  state <= HOLD;
               end else begin
                  cnt   <= cnt + CW'(1);
                  state <= ADD;
               end
            end
            HOLD: begin
               if (!run_sync)
                  state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Load_Clear takes priority over a simultaneous start while idle.
   assign Clr_Ld = (state == IDLE) & ld_sync;
   assign Clr_A  = (state == CLRA);
   assign Add    = (state == ADD) & M & ~last_step;
   assign Sub    = (state == ADD) & M &  last_step;
   assign Shift  = (state == SHIFT);
   assign Busy   = (state == CLRA) | (state == ADD) | (state == SHIFT);
   assign Done   = (state == HOLD);

endmodule

// File: tb/tb_mult_control.sv
// Scoreboard bench for mult_control: each multiplication's expected pulse counts are queued
// at press time and compared when the Busy episode ends.
module tb_mult_control;

   import mult_ctrl_pkg::*;

   logic Clk = 1'b0;
   logic Reset_n, Run, Load_Clear, M;
   logic Clr_Ld, Clr_A, Add, Sub, Shift, Busy, Done;

   mult_control #(.NUM_BITS(8)) dut (
      .Clk        (Clk),
      .Reset_n    (Reset_n),
      .Run        (Run),
      .Load_Clear (Load_Clear),
      .M          (M),
      .Clr_Ld     (Clr_Ld),
      .Clr_A      (Clr_A),
      .Add        (Add),
      .Sub        (Sub),
      .Shift      (Shift),
      .Busy       (Busy),
      .Done       (Done)
   );

   always #5 Clk = ~Clk;

   int checks   = 0;
   int failures = 0;

   task automatic check(input string tag, input int obs, input int expv);
      checks++;
      if (obs !== expv) begin
         failures++;
         $display("FAIL %s: got %0d, expected %0d", tag, obs, expv);
      end
   endtask

   typedef struct {
      int busy;
      int adds;
      int subs;
      int shifts;
      int clra;
      int done;
   } exp_t;

   exp_t sb[$];

   int         m_mode = 1;
   logic [7:0] b_reg  = 8'h00;
   logic [7:0] b_sw   = 8'h00;
   int         cyc    = 0;

   // Minimal datapath model: B loads on Clr_Ld and shifts right on Shift, M follows B[0].
   always_comb M = (m_mode == 2) ? b_reg[0] : m_mode[0];

   always @(posedge Clk) begin
      cyc <= cyc + 1;
      if (Clr_Ld)     b_reg <= b_sw;
      else if (Shift) b_reg <= {1'b0, b_reg[7:1]};
   end

   int   b_len = 0, n_add = 0, n_sub = 0, n_shift = 0, n_clra = 0;
   int   ep_cnt = 0, cl_cnt = 0, first_cl = -1;
   logic in_ep = 1'b0;
   logic busy_any = 1'b0;

   always @(negedge Clk) begin
      exp_t e;
      check("onehot", int'($countones({Clr_Ld, Clr_A, Add, Sub, Shift}) <= 1), 1);
      if (Clr_Ld) begin
         cl_cnt++;
         if (first_cl < 0) first_cl = cyc;
      end
      if (Busy) begin
         busy_any = 1'b1;
         if (!in_ep) begin
            b_len = 0; n_add = 0; n_sub = 0; n_shift = 0; n_clra = 0;
         end
         b_len++;
         n_add   += int'(Add);
         n_sub   += int'(Sub);
         n_shift += int'(Shift);
         n_clra  += int'(Clr_A);
      end else if (in_ep) begin
         ep_cnt++;
         if (sb.size() == 0) begin
            check("unexpected_episode", 1, 0);
         end else begin
            e = sb.pop_front();
            check("busy_len", b_len,   e.busy);
            check("adds",     n_add,   e.adds);
            check("subs",     n_sub,   e.subs);
            check("shifts",   n_shift, e.shifts);
            check("clr_a",    n_clra,  e.clra);
            check("done",     int'(Done), e.done);
         end
      end
      in_ep = Busy;
   end

   task automatic tick(input int n);
      repeat (n) @(posedge Clk);
      #1;
   endtask

   task automatic push(input int busy, input int adds, input int subs, input int shifts,
                       input int clra, input int done);
      exp_t e;
      e.busy = busy; e.adds = adds; e.subs = subs;
      e.shifts = shifts; e.clra = clra; e.done = done;
      sb.push_back(e);
   endtask

   task automatic wait_sb(input int budget);
      for (int i = 0; i < budget && sb.size() != 0; i++) @(posedge Clk);
      #1;
      if (sb.size() != 0) begin
         check("timeout", int'(sb.size()), 0);
         sb.delete();
      end
   endtask

   function automatic int ctrl_bits();
      return int'({Clr_Ld, Clr_A, Add, Sub, Shift, Busy, Done});
   endfunction

   initial begin
      int ep0;
      int hit;
      Reset_n    = 1'b0;
      Run        = 1'b1;
      Load_Clear = 1'b0;
      m_mode     = 1;

      // Reset with Run held: everything quiet, then exactly one start after release.
      tick(4);
      check("rst_outputs", ctrl_bits(), 0);
      check("rst_state", int'(dut.state), int'(IDLE));
      push(17, 7, 1, 8, 1, 1);
      Reset_n = 1'b1;
      tick(1);
      check("no_pulse_after_release", ctrl_bits(), 0);
      wait_sb(100);
      check("done_while_held", int'(Done), 1);
      Run = 1'b0;
      tick(4);
      check("hold_exit", int'(dut.state), int'(IDLE));
      check("eps_after_reset", ep_cnt, 1);

      // Load_Clear for 3 cycles: Clr_Ld for 3 cycles, 2 cycles after the press, never busy.
      cl_cnt = 0; first_cl = -1; busy_any = 1'b0;
      hit = cyc;
      Load_Clear = 1'b1;
      tick(3);
      Load_Clear = 1'b0;
      tick(6);
      check("load_count", cl_cnt, 3);
      check("load_latency", first_cl - hit, 2);
      check("load_busy", int'(busy_any), 0);

      // M held 0: shifts only.
      m_mode = 0;
      push(17, 0, 0, 8, 1, 1);
      Run = 1'b1; tick(3); Run = 1'b0;
      wait_sb(100);
      tick(4);

      // Multiplier pattern from B register: adds follow B[6:0], sub follows B[7].
      m_mode = 2;
      b_sw = 8'hA5;
      Load_Clear = 1'b1; tick(1); Load_Clear = 1'b0; tick(4);
      push(17, 3, 1, 8, 1, 1);
      Run = 1'b1; tick(2); Run = 1'b0;
      wait_sb(100);
      tick(4);
      b_sw = 8'h5A;
      Load_Clear = 1'b1; tick(1); Load_Clear = 1'b0; tick(4);
      push(17, 4, 0, 8, 1, 1);
      Run = 1'b1; tick(2); Run = 1'b0;
      wait_sb(100);
      tick(4);

      // Run held for 50 cycles: one multiplication; a second press gives a second.
      m_mode = 1;
      ep0 = ep_cnt;
      push(17, 7, 1, 8, 1, 1);
      Run = 1'b1;
      tick(50);
      check("held_one_mult", ep_cnt - ep0, 1);
      check("held_done", int'(Done), 1);
      Run = 1'b0;
      tick(4);
      push(17, 7, 1, 8, 1, 1);
      Run = 1'b1; tick(3); Run = 1'b0;
      wait_sb(100);
      check("second_press", ep_cnt - ep0, 2);
      tick(4);

      // Abort: reset during the multiplication, no further control pulses.
      push(6, 3, 0, 2, 1, 0);
      Run = 1'b1;
      hit = 0;
      for (int i = 0; i < 100 && hit == 0; i++) begin
         @(posedge Clk);
         if (in_ep && b_len == 6) hit = 1;
      end
      check("abort_reached", hit, 1);
      #1;
      Reset_n = 1'b0;
      #1;
      check("abort_outputs", ctrl_bits(), 0);
      tick(2);
      check("abort_state", int'(dut.state), int'(IDLE));
      Run = 1'b0;
      Reset_n = 1'b1;
      ep0 = ep_cnt;
      tick(6);
      check("abort_quiet", ctrl_bits(), 0);
      check("abort_no_episode", ep_cnt - ep0, 0);
      wait_sb(10);

      // Load_Clear and Run together: load wins, start discarded until re-press.
      cl_cnt = 0;
      ep0 = ep_cnt;
      Run = 1'b1; Load_Clear = 1'b1;
      tick(3);
      Load_Clear = 1'b0;
      tick(8);
      check("both_clr_ld", cl_cnt, 3);
      check("both_no_start", ep_cnt - ep0, 0);
      Run = 1'b0;
      tick(4);
      push(17, 7, 1, 8, 1, 1);
      Run = 1'b1; tick(2); Run = 1'b0;
      wait_sb(100);
      check("repress_start", ep_cnt - ep0, 1);
      tick(4);
      check("sb_empty", int'(sb.size()), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
